heavyhash_job_feeder: RTL and testbench
=======================================

Name: heavyhash_job_feeder

Overview:
- Write-side producer for the matrix multiplier's input FIFOs.
- Takes one job at a time from the host-facing stream and splits it into two parts:
  - an optional matrix part, pushed into the matrix FIFO;
  - a mandatory hash-input part, pushed into the hashin FIFO.
- Enforces job framing (word counts against s_last), throttles on FIFO full and reports completion and framing errors.
- Sits between the shell/stream adapter and the matrix FIFO / hashin FIFO that the multiplier controller drains.

Parameters:
- DW, 64, stream and FIFO word width.
- M_WORDS, 1024, matrix words per job (64 columns x 16 words); must be >= 2.
- H_WORDS, 4, hash-input words per job; must be >= 1.
- CW, 11, counter width; must satisfy 2^CW > max(M_WORDS, H_WORDS).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- job_valid  in  1  job header valid.
- job_has_matrix  in  1  header: job carries M_WORDS matrix words before the hash words.
- job_ready  out  1  header accepted when job_valid & job_ready.
- s_data  in  DW  payload word.
- s_valid  in  1  payload valid.
- s_last  in  1  marks final word of a job.
- s_ready  out  1  payload accepted when s_valid & s_ready.
- m_full  in  1  matrix FIFO full.
- m_we  out  1  matrix FIFO write enable.
- m_wdata  out  DW  matrix FIFO write data.
- h_full  in  1  hashin FIFO full.
- h_we  out  1  hashin FIFO write enable.
- h_wdata  out  DW  hashin FIFO write data.
- busy  out  1  high in any state other than IDLE.
- job_done  out  1  one-cycle pulse, registered, on a good job end.
- frame_err  out  1  one-cycle pulse, registered, on a framing error.
- jobs_ok  out  32  count of good jobs; wraps.
- err_cnt  out  16  count of framing errors; saturates at 16'hFFFF.

Behaviour:
- Reset (rst_n low at a clock edge):
  - state goes to IDLE and the word counter to 0;
  - job_done, frame_err, jobs_ok and err_cnt go to 0;
  - combinational outputs follow IDLE: job_ready=1, s_ready=0, m_we=h_we=0, busy=0.
  - Reset mid-job abandons the job silently. Words already written stay in the FIFOs; this block does no FIFO flush.
- Write path is combinational from the handshake:
  - m_we = s_valid & s_ready in M_LOAD; h_we likewise in H_LOAD;
  - m_wdata = h_wdata = s_data;
  - zero added latency; the FIFO captures on the same edge as the handshake.
- s_ready:
  - M_LOAD: !m_full;
  - H_LOAD: !h_full;
  - FLUSH: 1;
  - IDLE: 0.
- IDLE:
  - job_ready=1.
  - On a header handshake, clear the counter and go to M_LOAD if job_has_matrix, else H_LOAD.
  - Payload is never accepted in IDLE.
- M_LOAD, on each handshake:
  - If s_last=1: the word is not written (m_we forced 0), frame_err pulses, go to IDLE.
  - Else if cnt==M_WORDS-1: write, clear cnt, go to H_LOAD.
  - Else: write, cnt++.
- H_LOAD, on each handshake:
  - If cnt<H_WORDS-1 and s_last=1: early end; word dropped (h_we=0), frame_err, go to IDLE.
  - If cnt==H_WORDS-1 and s_last=1: write, job_done pulses, jobs_ok++, go to IDLE.
  - If cnt==H_WORDS-1 and s_last=0: write, frame_err, go to FLUSH.
  - Otherwise: write, cnt++.
- FLUSH:
  - Discard every accepted word; no FIFO write.
  - On a handshake with s_last=1, go to IDLE.
- Full handling: if the FIFO is full, s_ready=0 and the counter holds. There is no overflow path.
- Simultaneity: the full flags are sampled in the same cycle as the handshake. A write in the cycle full rises is legal, because the FIFO full flag is defined as "cannot accept next edge".
- Pulse timing:
  - job_done and frame_err assert the cycle after the triggering handshake and last one cycle.
  - They are never asserted together.
  - err_cnt increments on each frame_err.
- Back-to-back: the next header can be accepted the cycle after returning to IDLE.
  - Minimum job period is M_WORDS+H_WORDS+1 cycles (matrix job) or H_WORDS+1 cycles (hash-only job).

Decomposition:
- Shared package heavyhash_pkg holds:
  - the feeder_state_t enum (IDLE, M_LOAD, H_LOAD, FLUSH);
  - default constants M_WORDS_DEF and H_WORDS_DEF, shared with matrix_controller sizing.
- One natural sub-module: hh_stat_counters, holding jobs_ok (wrapping) and err_cnt (saturating), fed by the job_done and frame_err pulses.
- FSM, word counter and write steering stay in the top module.

Test Plan:
- Matrix job, no backpressure: header has_matrix=1, then 1028 words, last word with s_last → exactly 1024 m_we then 4 h_we in order; job_done pulses once; jobs_ok=1; total 1029 cycles from header.
- Hash-only job with h_full toggling every other cycle: 4 words with s_last on the 4th → h_we only when h_full=0; data order preserved; no m_we; jobs_ok increments.
- Early s_last on hash word 2 (hash-only job) → 2 words written, the s_last word dropped, frame_err pulse, err_cnt=1, job_ready=1 next cycle.
- Missing s_last: 4 hash words with s_last=0, then 3 extra words with s_last on the 3rd → 4 h_we, frame_err once, extras discarded, back in IDLE.
- rst_n low during M_LOAD at word 500 → next cycle idle outputs, counters 0; new matrix job then completes with exactly 1024 m_we.
- err_cnt preloaded near saturation by 65536 error jobs → holds at 16'hFFFF; jobs_ok wraps 32'hFFFFFFFF→0 on a forced-count run.

Source files
------------

// File: rtl/heavyhash_job_feeder_pkg.sv
// Shared definitions for the HeavyHash job feeder and the matrix controller sizing.
package heavyhash_pkg;

    typedef enum logic [1:0] {
        FS_IDLE   = 2'd0,
        FS_M_LOAD = 2'd1,
        FS_H_LOAD = 2'd2,
        FS_FLUSH  = 2'd3
    } feeder_state_t;

    localparam int DW_DEF      = 64;
    localparam int M_WORDS_DEF = 1024;
    localparam int H_WORDS_DEF = 4;
    localparam int CW_DEF      = 11;

endpackage

// File: rtl/heavyhash_job_feeder_if.sv
// Job header, payload stream and FIFO write ports of the feeder, bundled as one interface.
interface heavyhash_job_feeder_if #(
    parameter int DW = 64
);
    logic          job_valid;
    logic          job_has_matrix;
    logic          job_ready;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_last;
    logic          s_ready;
    logic          m_full;
    logic          m_we;
    logic [DW-1:0] m_wdata;
    logic          h_full;
    logic          h_we;
    logic [DW-1:0] h_wdata;

    // Feeder side.
    modport master (
        input  job_valid, job_has_matrix, s_data, s_valid, s_last, m_full, h_full,
        output job_ready, s_ready, m_we, m_wdata, h_we, h_wdata
    );

    // Host stream and FIFO side.
    modport slave (
        output job_valid, job_has_matrix, s_data, s_valid, s_last, m_full, h_full,
        input  job_ready, s_ready, m_we, m_wdata, h_we, h_wdata
    );
endinterface

// File: rtl/heavyhash_job_feeder_stat_counters.sv
// Job statistics: wrapping good-job count and saturating framing-error count.
module hh_stat_counters #(
    parameter int OK_W  = 32,
    parameter int ERR_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_ok,
    input  logic             inc_err,
    output logic [OK_W-1:0]  jobs_ok,
    output logic [ERR_W-1:0] err_cnt
);

    // Counter update; the error count sticks at all-ones.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            jobs_ok <= {OK_W{1'b0}};
            err_cnt <= {ERR_W{1'b0}};
        end else begin
            if (inc_ok) begin
                jobs_ok <= jobs_ok + OK_W'(1);
            end
            if (inc_err && (err_cnt != {ERR_W{1'b1}})) begin
                err_cnt <= err_cnt + ERR_W'(1);
            end
        end
    end

endmodule

// File: rtl/heavyhash_job_feeder.sv
// Splits each host job into matrix words and hash-input words for the multiplier FIFOs,
// enforcing the per-job word counts against s_last.
module heavyhash_job_feeder
    import heavyhash_pkg::*;
#(
    parameter int DW      = DW_DEF,
    parameter int M_WORDS = M_WORDS_DEF,
    parameter int H_WORDS = H_WORDS_DEF,
    parameter int CW      = CW_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    heavyhash_job_feeder_if.master        bus,
    output logic                          busy,
    output logic                          job_done,
    output logic                          frame_err,
    output logic [31:0]                   jobs_ok,
    output logic [15:0]                   err_cnt
);

    localparam logic [1:0] IDLE   = FS_IDLE;
    localparam logic [1:0] M_LOAD = FS_M_LOAD;
    localparam logic [1:0] H_LOAD = FS_H_LOAD;
    localparam logic [1:0] FLUSH  = FS_FLUSH;

    localparam logic [CW-1:0] M_LAST = CW'(M_WORDS - 1);
    localparam logic [CW-1:0] H_LAST = CW'(H_WORDS - 1);

    logic [1:0]    state_r;
    logic [1:0]    state_next_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_next_s;
    logic          done_r;
    logic          err_r;
    logic          set_done_s;
    logic          set_err_s;
    logic          job_ready_s;
    logic          s_ready_s;
    logic          m_we_s;
    logic          h_we_s;
    logic          hs_s;
    logic [DW-1:0] word_s;

    assign hs_s   = bus.s_valid & s_ready_s;
    assign word_s = bus.s_data;

    // Next-state, counter and write-steering decode.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        set_done_s   = 1'b0;
        set_err_s    = 1'b0;
        job_ready_s  = 1'b0;
        s_ready_s    = 1'b0;
        m_we_s       = 1'b0;
        h_we_s       = 1'b0;
        case (state_r)
            IDLE: begin
                job_ready_s = 1'b1;
                if (bus.job_valid) begin
                    cnt_next_s   = {CW{1'b0}};
                    state_next_s = bus.job_has_matrix ? M_LOAD : H_LOAD;
                end else begin
                    state_next_s = IDLE;
                end
            end
            M_LOAD: begin
                s_ready_s = ~bus.m_full;
                if (hs_s) begin
                    if (bus.s_last) begin
                        // A job that ends inside the matrix part is malformed; drop the word.
                        set_err_s    = 1'b1;
                        state_next_s = IDLE;
                    end else if (cnt_r == M_LAST) begin
                        m_we_s       = 1'b1;
                        cnt_next_s   = {CW{1'b0}};
                        state_next_s = H_LOAD;
                    end else begin
                        m_we_s     = 1'b1;
                        cnt_next_s = cnt_r + CW'(1);
                    end
                end else begin
                    cnt_next_s = cnt_r;
                end
            end
            H_LOAD: begin
                s_ready_s = ~bus.h_full;
                if (hs_s) begin
                    if (cnt_r == H_LAST) begin
                        h_we_s = 1'b1;
                        if (bus.s_last) begin
                            set_done_s   = 1'b1;
                            state_next_s = IDLE;
                        end else begin
                            // Job overran its hash part: keep the full set, discard the rest.
                            set_err_s    = 1'b1;
                            state_next_s = FLUSH;
                        end
                    end else if (bus.s_last) begin
                        set_err_s    = 1'b1;
                        state_next_s = IDLE;
                    end else begin
                        h_we_s     = 1'b1;
                        cnt_next_s = cnt_r + CW'(1);
                    end
                end else begin
                    cnt_next_s = cnt_r;
                end
            end
            FLUSH: begin
                s_ready_s = 1'b1;
                if (hs_s && bus.s_last) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = FLUSH;
                end
            end
            default: begin
                state_next_s = IDLE;
                cnt_next_s   = {CW{1'b0}};
            end
        endcase
    end

    // State, word counter and status pulse registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= {CW{1'b0}};
            done_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            done_r  <= set_done_s;
            err_r   <= set_err_s;
        end
    end

    assign bus.job_ready = job_ready_s;
    assign bus.s_ready   = s_ready_s;
    assign bus.m_we      = m_we_s;
    assign bus.h_we      = h_we_s;
    assign bus.m_wdata   = word_s;
    assign bus.h_wdata   = word_s;

    assign busy      = (state_r != IDLE);
    assign job_done  = done_r;
    assign frame_err = err_r;

    hh_stat_counters #(
        .OK_W  (32),
        .ERR_W (16)
    ) u_stats (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_ok  (done_r),
        .inc_err (err_r),
        .jobs_ok (jobs_ok),
        .err_cnt (err_cnt)
    );

endmodule

// File: tb/tb_heavyhash_job_feeder.sv
// Directed self-checking bench for heavyhash_job_feeder.
module tb_heavyhash_job_feeder;

    logic        clk;
    logic        rst_n;
    logic        busy;
    logic        job_done;
    logic        frame_err;
    logic [31:0] jobs_ok;
    logic [15:0] err_cnt;

    logic        st_ok;
    logic        st_err;
    logic [2:0]  st_jobs;
    logic [1:0]  st_errs;

    int checks;
    int errors;
    int cyc;
    int done_pulses;
    int err_pulses;
    int both_pulses;
    int we_while_full;
    int hdr_cyc;
    int last_cyc;
    logic toggle_en;
    logic [63:0] m_q[$];
    logic [63:0] h_q[$];

    heavyhash_job_feeder_if #(.DW(64)) bus ();

    heavyhash_job_feeder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.master),
        .busy      (busy),
        .job_done  (job_done),
        .frame_err (frame_err),
        .jobs_ok   (jobs_ok),
        .err_cnt   (err_cnt)
    );

    hh_stat_counters #(.OK_W(3), .ERR_W(2)) u_stat_small (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_ok  (st_ok),
        .inc_err (st_err),
        .jobs_ok (st_jobs),
        .err_cnt (st_errs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Observe FIFO writes and status pulses mid-cycle.
    always @(negedge clk) begin
        if (bus.m_we) m_q.push_back(bus.m_wdata);
        if (bus.h_we) h_q.push_back(bus.h_wdata);
        if (bus.h_we && bus.h_full) we_while_full <= we_while_full + 1;
        if (bus.m_we && bus.m_full) we_while_full <= we_while_full + 1;
        if (job_done) done_pulses <= done_pulses + 1;
        if (frame_err) err_pulses <= err_pulses + 1;
        if (job_done && frame_err) both_pulses <= both_pulses + 1;
    end

    initial begin
        toggle_en = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (toggle_en) bus.h_full = ~bus.h_full;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_header(input logic has_m);
        logic rdy;
        int   n;
        bus.job_valid      = 1'b1;
        bus.job_has_matrix = has_m;
        rdy = 1'b0;
        n   = 0;
        while (!rdy && n < 64) begin
            @(negedge clk);
            rdy     = bus.job_ready;
            hdr_cyc = cyc;
            @(posedge clk);
            #1;
            n++;
        end
        bus.job_valid      = 1'b0;
        bus.job_has_matrix = 1'b0;
        if (!rdy) check_eq("hdr_timeout", 64'd1, 64'd0);
    endtask

    task automatic send_word(input logic [63:0] d, input logic last);
        logic rdy;
        int   n;
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        bus.s_last  = last;
        rdy = 1'b0;
        n   = 0;
        while (!rdy && n < 64) begin
            @(negedge clk);
            rdy      = bus.s_ready;
            last_cyc = cyc;
            @(posedge clk);
            #1;
            n++;
        end
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        if (!rdy) check_eq("word_timeout", 64'd1, 64'd0);
    endtask

    task automatic clear_obs();
        m_q.delete();
        h_q.delete();
        done_pulses = 0;
        err_pulses  = 0;
    endtask

    task automatic run_matrix_job(input logic [63:0] base);
        send_header(1'b1);
        for (int i = 0; i < 1024; i++) send_word(base | 64'(i), 1'b0);
        for (int j = 0; j < 4; j++) send_word(64'hB000_0000_0000_0000 | 64'(j), (j == 3));
    endtask

    initial begin
        int bad;
        checks = 0; errors = 0; cyc = 0;
        done_pulses = 0; err_pulses = 0; both_pulses = 0; we_while_full = 0;
        rst_n = 1'b0;
        st_ok = 1'b0; st_err = 1'b0;
        bus.job_valid = 1'b0; bus.job_has_matrix = 1'b0;
        bus.s_data = 64'd0; bus.s_valid = 1'b0; bus.s_last = 1'b0;
        bus.m_full = 1'b0; bus.h_full = 1'b0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_job_ready", 64'(bus.job_ready), 64'd1);
        check_eq("rst_s_ready", 64'(bus.s_ready), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_we", 64'({bus.m_we, bus.h_we}), 64'd0);
        check_eq("rst_pulses", 64'({job_done, frame_err}), 64'd0);
        check_eq("rst_jobs_ok", 64'(jobs_ok), 64'd0);
        check_eq("rst_err_cnt", 64'(err_cnt), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Matrix job without backpressure.
        clear_obs();
        run_matrix_job(64'hA000_0000_0000_0000);
        repeat (3) @(posedge clk);
        #1;
        check_eq("mx_m_count", 64'(m_q.size()), 64'd1024);
        check_eq("mx_h_count", 64'(h_q.size()), 64'd4);
        bad = 0;
        for (int i = 0; i < m_q.size(); i++) if (m_q[i] !== (64'hA000_0000_0000_0000 | 64'(i))) bad++;
        for (int j = 0; j < h_q.size(); j++) if (h_q[j] !== (64'hB000_0000_0000_0000 | 64'(j))) bad++;
        check_eq("mx_order", 64'(bad), 64'd0);
        check_eq("mx_span", 64'(last_cyc - hdr_cyc), 64'd1028);
        check_eq("mx_done", 64'(done_pulses), 64'd1);
        check_eq("mx_err", 64'(err_pulses), 64'd0);
        check_eq("mx_jobs_ok", 64'(jobs_ok), 64'd1);
        check_eq("mx_busy", 64'(busy), 64'd0);

        // Hash-only job with h_full toggling.
        clear_obs();
        send_header(1'b0);
        check_eq("ho_busy", 64'(busy), 64'd1);
        toggle_en = 1'b1;
        for (int j = 0; j < 4; j++) send_word(64'hC000_0000_0000_0010 + 64'(j), (j == 3));
        toggle_en = 1'b0;
        bus.h_full = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("ho_h_count", 64'(h_q.size()), 64'd4);
        bad = 0;
        for (int j = 0; j < h_q.size(); j++) if (h_q[j] !== (64'hC000_0000_0000_0010 + 64'(j))) bad++;
        check_eq("ho_order", 64'(bad), 64'd0);
        check_eq("ho_m_count", 64'(m_q.size()), 64'd0);
        check_eq("ho_we_full", 64'(we_while_full), 64'd0);
        check_eq("ho_done", 64'(done_pulses), 64'd1);
        check_eq("ho_jobs_ok", 64'(jobs_ok), 64'd2);

        // Early s_last on hash word 2.
        clear_obs();
        send_header(1'b0);
        send_word(64'h11, 1'b0);
        send_word(64'h22, 1'b0);
        send_word(64'h33, 1'b1);
        check_eq("early_job_ready", 64'(bus.job_ready), 64'd1);
        check_eq("early_frame_err", 64'(frame_err), 64'd1);
        repeat (2) @(posedge clk);
        #1;
        check_eq("early_h_count", 64'(h_q.size()), 64'd2);
        check_eq("early_err_pulses", 64'(err_pulses), 64'd1);
        check_eq("early_err_cnt", 64'(err_cnt), 64'd1);
        check_eq("early_done", 64'(done_pulses), 64'd0);
        check_eq("early_jobs_ok", 64'(jobs_ok), 64'd2);

        // Missing s_last: extras flushed.
        clear_obs();
        send_header(1'b0);
        for (int j = 0; j < 4; j++) send_word(64'h40 + 64'(j), 1'b0);
        for (int j = 0; j < 3; j++) send_word(64'h50 + 64'(j), (j == 2));
        repeat (2) @(posedge clk);
        #1;
        check_eq("miss_h_count", 64'(h_q.size()), 64'd4);
        check_eq("miss_last_word", (h_q.size() == 4) ? h_q[3] : 64'hDEAD, 64'h43);
        check_eq("miss_err_pulses", 64'(err_pulses), 64'd1);
        check_eq("miss_err_cnt", 64'(err_cnt), 64'd2);
        check_eq("miss_idle", 64'({busy, bus.job_ready}), 64'b01);

        // s_last inside the matrix part.
        clear_obs();
        send_header(1'b1);
        for (int i = 0; i < 5; i++) send_word(64'h60 + 64'(i), (i == 4));
        repeat (2) @(posedge clk);
        #1;
        check_eq("mlast_m_count", 64'(m_q.size()), 64'd4);
        check_eq("mlast_h_count", 64'(h_q.size()), 64'd0);
        check_eq("mlast_err_cnt", 64'(err_cnt), 64'd3);
        check_eq("pulse_overlap", 64'(both_pulses), 64'd0);

        // Reset mid matrix load at word 500.
        send_header(1'b1);
        for (int i = 0; i < 500; i++) send_word(64'h70 + 64'(i), 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_eq("mrst_idle", 64'({bus.job_ready, bus.s_ready, busy}), 64'b100);
        check_eq("mrst_we", 64'({bus.m_we, bus.h_we}), 64'd0);
        check_eq("mrst_counts", 64'({jobs_ok, err_cnt}), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        clear_obs();
        run_matrix_job(64'hD000_0000_0000_0000);
        repeat (3) @(posedge clk);
        #1;
        check_eq("mrst_m_count", 64'(m_q.size()), 64'd1024);
        check_eq("mrst_h_count", 64'(h_q.size()), 64'd4);
        check_eq("mrst_jobs_ok", 64'(jobs_ok), 64'd1);

        // Narrow statistics counters: wrap and saturation.
        st_ok = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        check_eq("st_ok_7", 64'(st_jobs), 64'd7);
        @(posedge clk);
        #1;
        st_ok = 1'b0;
        check_eq("st_ok_wrap", 64'(st_jobs), 64'd0);
        st_err = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("st_err_2", 64'(st_errs), 64'd2);
        repeat (3) @(posedge clk);
        #1;
        st_err = 1'b0;
        check_eq("st_err_sat", 64'(st_errs), 64'd3);
        check_eq("st_ok_hold", 64'(st_jobs), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
